gvp_sequencer: RTL and testbench
================================

// Module: gvp_sequencer
// PURPOSE
//  Run-control and program-load sequencer for the GVP vector core. Turns a 32-bit AXI-Stream of
//  vector words into 512-bit vp_set/setvec writes, held long enough for the decimated GVP to see.
//  Sequences GVP reset/run/pause from host commands, detects program completion, blanks the stale
//  finished flag after reset release. Sits between PS-side config/DMA registers and gvp.
// PARAMETERS
//  NUM_VECTORS_N2  4   log2 of GVP vector slots; word0[NUM_VECTORS_N2:0] is the slot address
//  SETVEC_HOLD     32  cycles setvec held high, then low, per record; must exceed max GVP decimation
//  RESET_SETTLE    16  min cycles gvp_reset high before RUN; also finished-blanking window (>=10)
// PORTS
//  a_clk           in   1    system clock (GVP clock domain)
//  a_resetn        in   1    asynchronous, active-low reset
//  s_axis_tdata    in   32   vector record words; 16 words per record, word0 first
//  s_axis_tvalid   in   1    word valid
//  s_axis_tlast    in   1    must be high on word15 of each record only
//  s_axis_tready   out  1    word accepted when tvalid&tready
//  cmd_load        in   1    1-cycle pulse: enter program-load mode (GVP held in reset)
//  cmd_start       in   1    1-cycle pulse: release GVP reset and run the program
//  cmd_abort       in   1    1-cycle pulse: return to IDLE, GVP reset reasserted; highest priority
//  cmd_pause       in   1    level: pause request, forwarded only in RUN
//  gvp_finished    in   1    GVP finished flag
//  gvp_reset       out  1    GVP reset/hold (active high)
//  gvp_pause       out  1    GVP pause
//  gvp_setvec      out  1    GVP vector write strobe (level, SETVEC_HOLD cycles)
//  gvp_vp_set      out  512  assembled record; word k at [32k+31:32k]
//  state           out  3    0 IDLE,1 COLLECT,2 WRITE,3 GAP,4 RUN,5 DONE
//  vectors_loaded  out  8    records written since last cmd_load (saturates at 255)
//  run_done        out  1    high in DONE
//  err_framing     out  1    sticky: tlast mismatch seen; cleared by cmd_load
// BEHAVIOUR
//  Reset: state=IDLE, gvp_reset=1, gvp_pause=0, gvp_setvec=0, gvp_vp_set=0, tready=0,
//   vectors_loaded=0, run_done=0, err_framing=0, settle counter=0.
//  Priority per cycle: cmd_abort > cmd_load > cmd_start. Other commands ignored where unlisted.
//  IDLE: gvp_reset=1; settle counter counts to RESET_SETTLE, saturates. cmd_load -> COLLECT
//   (clears vectors_loaded, err_framing, word index). cmd_start -> RUN only if settle done.
//  COLLECT: gvp_reset=1, tready=1. Each handshake writes word[w], w++. Handshake with
//   tlast=1 at w<15, or tlast=0 at w=15 -> err_framing=1, record discarded, w=0, stay.
//   Correct word15 -> WRITE next cycle (tready=0 from that cycle). cmd_start accepted only at
//   w=0 (settle done by construction) -> RUN; mid-record cmd_start ignored.
//  WRITE: gvp_setvec=1, gvp_vp_set stable, for exactly SETVEC_HOLD cycles -> GAP.
//  GAP: gvp_setvec=0 for SETVEC_HOLD cycles; vectors_loaded++ on entry; -> COLLECT, w=0.
//   cmd_start in WRITE/GAP ignored; cmd_abort aborts immediately (setvec drops same cycle).
//  RUN: gvp_reset=0; gvp_pause=cmd_pause (registered, 1-cycle latency). Blanking counter
//   ignores gvp_finished for first RESET_SETTLE cycles; after that gvp_finished=1 -> DONE.
//  DONE: gvp_reset=0 (GVP holds finished state), gvp_pause=0, run_done=1. cmd_start ignored.
//   cmd_load -> COLLECT, cmd_abort -> IDLE; both reassert gvp_reset and clear settle counter.
//  All outputs registered; command-to-output latency 1 cycle. Settle counter cleared on every
//   entry to IDLE/COLLECT from RUN/DONE, so a restart always sees >=RESET_SETTLE reset cycles.
//  Counters saturate, never wrap. a_resetn mid-WRITE drops setvec asynchronously; partially
//   collected record is lost.
// STRUCTURE
//  gvp_seq_defs.vh: state encodings, WORDS_PER_REC=16, word index width.
//  Sub-module gvp_vec_assembler: word index, 16x32 register file, tlast framing check,
//   outputs rec_valid/err pulse and 512-bit record; FSM/counters remain in gvp_sequencer.
// TESTING
//  Reset, then cmd_start at cycle 5 -> ignored until settle=16; cmd_start at cycle 20 -> RUN, gvp_reset=0.
//  cmd_load + 3 records (word0=0,1,2) -> each setvec high 32 cycles, vp_set[63:32]=word1; vectors_loaded=3.
//  Record with tlast on word 7 -> err_framing=1, no setvec, next good record accepted and written.
//  RUN with gvp_finished stuck 1 from prior run -> no DONE within 16 cycles; DONE on cycle 17.
//  cmd_pause level in RUN -> gvp_pause follows 1 cycle later; in DONE/IDLE gvp_pause=0.
//  cmd_abort at WRITE cycle 10 -> setvec=0, IDLE, gvp_reset=1 next cycle; a_resetn pulse mid-RUN -> reset values.

Source files
------------

// File: rtl/gvp_sequencer_pkg.sv
// Shared encodings and sizes for the GVP run-control / program-load sequencer.
// Imported by the assembler and the sequencer top.
package gvp_sequencer_pkg;

  localparam int WORDS_PER_REC = 16;
  localparam int WORD_IDX_W    = $clog2(WORDS_PER_REC);
  localparam int REC_W         = 32 * WORDS_PER_REC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_GAP     = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gvp_sequencer_if.sv
// AXI-Stream word channel carrying vector records into the sequencer.
interface gvp_sequencer_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);

endinterface

// File: rtl/gvp_sequencer_vec_assembler.sv
// Collects 16 stream words into one 512-bit record and checks tlast framing.
// rec_valid/rec_err are same-cycle decodes of the accepted word; the record itself is registered.
module gvp_vec_assembler
  import gvp_sequencer_pkg::*;
(
  input  logic             a_clk,
  input  logic             a_resetn,
  input  logic             enable,
  input  logic             accept,
  input  logic [31:0]      word,
  input  logic             last,
  output logic             at_first,
  output logic             rec_valid,
  output logic             rec_err,
  output logic [REC_W-1:0] record
);

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_REC - 1);

  logic [WORD_IDX_W-1:0] word_idx;
  logic [31:0]           words [WORDS_PER_REC];
  logic [REC_W-1:0]      rec_next;
  logic                  at_last;

  assign at_last   = (word_idx == LAST_IDX);
  assign at_first  = (word_idx == '0);
  assign rec_err   = accept && (last != at_last);
  assign rec_valid = accept && last && at_last;

  // Word 15 goes straight into the record, so the record is complete on the handshake edge
  always_comb begin
    rec_next = '0;
    for (int k = 0; k < WORDS_PER_REC - 1; k++) rec_next[32*k +: 32] = words[k];
    rec_next[REC_W-32 +: 32] = word;
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      word_idx <= '0;
      record   <= '0;
      for (int k = 0; k < WORDS_PER_REC; k++) words[k] <= '0;
    end else if (!enable) begin
      word_idx <= '0;
    end else if (accept) begin
      if (rec_err) begin
        word_idx <= '0;
      end else if (at_last) begin
        word_idx <= '0;
        record   <= rec_next;
      end else begin
        words[word_idx] <= word;
        word_idx        <= word_idx + WORD_IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/gvp_sequencer.sv
// GVP run-control and program-load sequencer: streams records into vp_set/setvec writes,
// sequences GVP reset/run/pause and blanks the stale finished flag after reset release.
module gvp_sequencer
  import gvp_sequencer_pkg::*;
#(
  parameter int NUM_VECTORS_N2 = 4,
  parameter int SETVEC_HOLD    = 32,
  parameter int RESET_SETTLE   = 16
) (
  input  logic             a_clk,
  input  logic             a_resetn,
  gvp_sequencer_if.slave   s_axis,
  input  logic             cmd_load,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic             cmd_pause,
  input  logic             gvp_finished,
  output logic             gvp_reset,
  output logic             gvp_pause,
  output logic             gvp_setvec,
  output logic [REC_W-1:0] gvp_vp_set,
  output logic [2:0]       state,
  output logic [7:0]       vectors_loaded,
  output logic             run_done,
  output logic             err_framing
);

  localparam int HOLD_W   = $clog2(SETVEC_HOLD + 1);
  localparam int SETTLE_W = $clog2(RESET_SETTLE + 1);

  // The slot address field word0[NUM_VECTORS_N2:0] has to fit in one stream word
  if (NUM_VECTORS_N2 < 0 || NUM_VECTORS_N2 > 30) begin : g_param_check
    $error("gvp_sequencer: NUM_VECTORS_N2 out of range");
  end

  seq_state_t            cur_state, next_state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [SETTLE_W-1:0]   blank_cnt;
  logic                  tready_q;
  logic                  accept, at_first, rec_valid, rec_err;
  logic                  hold_last, settle_done, blank_done, load_entry;

  assign s_axis.tready = tready_q;
  assign state         = cur_state;
  assign accept        = s_axis.tvalid && tready_q && (cur_state == ST_COLLECT) && !cmd_abort;
  assign hold_last     = (hold_cnt == HOLD_W'(SETVEC_HOLD - 1));
  assign settle_done   = (settle_cnt == SETTLE_W'(RESET_SETTLE));
  assign blank_done    = (blank_cnt == SETTLE_W'(RESET_SETTLE));

  gvp_vec_assembler u_assembler (
    .a_clk     (a_clk),
    .a_resetn  (a_resetn),
    .enable    (cur_state == ST_COLLECT),
    .accept    (accept),
    .word      (s_axis.tdata),
    .last      (s_axis.tlast),
    .at_first  (at_first),
    .rec_valid (rec_valid),
    .rec_err   (rec_err),
    .record    (gvp_vp_set)
  );

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) cur_state <= ST_IDLE;
    else           cur_state <= next_state;
  end

  // Abort overrides every other transition; load only restarts from IDLE or DONE
  always_comb begin
    next_state = cur_state;
    load_entry = 1'b0;
    unique case (cur_state)
      ST_IDLE: begin
        if (cmd_load) begin
          next_state = ST_COLLECT;
          load_entry = 1'b1;
        end else if (cmd_start && settle_done) begin
          next_state = ST_RUN;
        end
      end
      ST_COLLECT: begin
        if (rec_valid)                                   next_state = ST_WRITE;
        else if (!rec_err && cmd_start && at_first && settle_done) next_state = ST_RUN;
      end
      ST_WRITE: if (hold_last) next_state = ST_GAP;
      ST_GAP:   if (hold_last) next_state = ST_COLLECT;
      ST_RUN:   if (blank_done && gvp_finished) next_state = ST_DONE;
      ST_DONE: begin
        if (cmd_load) begin
          next_state = ST_COLLECT;
          load_entry = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (cmd_abort) begin
      next_state = ST_IDLE;
      load_entry = 1'b0;
    end
  end

  // Settle runs whenever GVP is held in reset and restarts from zero after any RUN/DONE
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      hold_cnt   <= '0;
      settle_cnt <= '0;
      blank_cnt  <= '0;
    end else begin
      if (next_state != cur_state)                            hold_cnt <= '0;
      else if (cur_state == ST_WRITE || cur_state == ST_GAP)  hold_cnt <= hold_cnt + HOLD_W'(1);

      if (cur_state == ST_RUN || cur_state == ST_DONE) settle_cnt <= '0;
      else if (!settle_done)                           settle_cnt <= settle_cnt + SETTLE_W'(1);

      if (cur_state != ST_RUN) blank_cnt <= '0;
      else if (!blank_done)    blank_cnt <= blank_cnt + SETTLE_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      gvp_reset      <= 1'b1;
      gvp_pause      <= 1'b0;
      gvp_setvec     <= 1'b0;
      tready_q       <= 1'b0;
      run_done       <= 1'b0;
      vectors_loaded <= '0;
      err_framing    <= 1'b0;
    end else begin
      gvp_reset  <= !(next_state == ST_RUN || next_state == ST_DONE);
      gvp_pause  <= (next_state == ST_RUN) && cmd_pause;
      gvp_setvec <= (next_state == ST_WRITE);
      tready_q   <= (next_state == ST_COLLECT);
      run_done   <= (next_state == ST_DONE);

      if (load_entry)                                          vectors_loaded <= '0;
      else if (cur_state == ST_WRITE && next_state == ST_GAP)  vectors_loaded <= sat_inc8(vectors_loaded);

      if (load_entry)   err_framing <= 1'b0;
      else if (rec_err) err_framing <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gvp_sequencer.sv
// Directed bench for gvp_sequencer with randomized record contents; records and strobe
// timing are checked against a queue-based model of what the host streamed in.
module tb_gvp_sequencer;

  logic         a_clk = 1'b0;
  logic         a_resetn = 1'b0;
  logic         cmd_load = 1'b0, cmd_start = 1'b0, cmd_abort = 1'b0, cmd_pause = 1'b0;
  logic         gvp_finished = 1'b0;
  logic         gvp_reset, gvp_pause, gvp_setvec, run_done, err_framing;
  logic [511:0] gvp_vp_set;
  logic [2:0]   state;
  logic [7:0]   vectors_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] exp_rec[$];
  logic [511:0] got_rec[$];
  int           got_len[$];
  int           got_gap[$];
  int           unstable = 0;
  logic         sv_prev = 1'b0;
  int           high_len = 0;
  int           gap_len = 0;

  always #5 a_clk = ~a_clk;

  gvp_sequencer_if s_axis();

  gvp_sequencer dut (
    .a_clk          (a_clk),
    .a_resetn       (a_resetn),
    .s_axis         (s_axis),
    .cmd_load       (cmd_load),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .cmd_pause      (cmd_pause),
    .gvp_finished   (gvp_finished),
    .gvp_reset      (gvp_reset),
    .gvp_pause      (gvp_pause),
    .gvp_setvec     (gvp_setvec),
    .gvp_vp_set     (gvp_vp_set),
    .state          (state),
    .vectors_loaded (vectors_loaded),
    .run_done       (run_done),
    .err_framing    (err_framing)
  );

  // Observe every setvec pulse: captured record, high length, stability, and GAP length
  always @(negedge a_clk) begin
    if (!a_resetn) begin
      sv_prev  = 1'b0;
      high_len = 0;
      gap_len  = 0;
    end else begin
      if (gvp_setvec) begin
        if (!sv_prev) begin
          got_rec.push_back(gvp_vp_set);
          high_len = 0;
        end
        high_len++;
        if (gvp_vp_set !== got_rec[$]) unstable++;
      end else if (sv_prev) begin
        got_len.push_back(high_len);
      end
      sv_prev = gvp_setvec;
      if (state == 3'd3) gap_len++;
      else if (gap_len != 0) begin
        got_gap.push_back(gap_len);
        gap_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) cmd_load  = 1'b1;
    if (which == 1) cmd_start = 1'b1;
    if (which == 2) cmd_abort = 1'b1;
    tick();
    cmd_load = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0;
  endtask

  task automatic waitState(input logic [2:0] target, input string tag);
    int budget = 300;
    while (state !== target && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput(tag, state, target);
  endtask

  // One stream word, with an occasional idle cycle before it; returns after the handshake edge
  task automatic applyStimulus(input logic [31:0] d, input logic l);
    int budget = 300;
    if ($urandom_range(0, 3) == 0) begin
      s_axis.tvalid = 1'b0;
      tick();
    end
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    while (!s_axis.tready && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) checkOutput("tready_timeout", 1'b0, 1'b1);
    tick();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // bad_at < 0: good record; 0..14: tlast early on that word; 15: tlast missing on word 15
  task automatic sendRecord(input logic [31:0] w0, input int bad_at);
    logic [511:0] rec;
    rec = '0;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] d;
      logic        l;
      d = (k == 0) ? w0 : $urandom;
      rec[32*k +: 32] = d;
      if (bad_at >= 0 && bad_at < 15) l = (k == bad_at);
      else if (bad_at == 15)          l = 1'b0;
      else                            l = (k == 15);
      applyStimulus(d, l);
      if (bad_at >= 0 && bad_at < 15 && k == bad_at) break;
    end
    if (bad_at < 0) exp_rec.push_back(rec);
  endtask

  task automatic checkRecords(input string tag);
    checkOutput({tag, "_count"}, got_rec.size(), exp_rec.size());
    for (int i = 0; i < exp_rec.size() && i < got_rec.size(); i++) begin
      checkOutput({tag, "_word1"}, got_rec[i][63:32], exp_rec[i][63:32]);
      checkOutput({tag, "_record"}, got_rec[i], exp_rec[i]);
    end
    for (int i = 0; i < got_len.size(); i++) checkOutput({tag, "_hold"}, got_len[i], 32);
    for (int i = 0; i < got_gap.size(); i++) checkOutput({tag, "_gap"}, got_gap[i], 32);
    exp_rec.delete(); got_rec.delete(); got_len.delete(); got_gap.delete();
  endtask

  initial begin
    s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_gvp_reset", gvp_reset, 1);
    checkOutput("rst_setvec", gvp_setvec, 0);
    checkOutput("rst_vp_set", gvp_vp_set, 0);
    checkOutput("rst_tready", s_axis.tready, 0);
    checkOutput("rst_misc", {gvp_pause, run_done, err_framing, vectors_loaded}, 0);
    @(posedge a_clk); #1;
    a_resetn = 1'b1;

    // Start before settling is ignored; start at edge 20 runs
    repeat (4) tick();
    pulse(1);
    checkOutput("early_start_ignored", state, 0);
    repeat (14) tick();
    pulse(1);
    checkOutput("start_run_state", state, 4);
    checkOutput("start_run_gvp_reset", gvp_reset, 0);

    // Pause follows the level one cycle later in RUN
    cmd_pause = 1'b1;
    checkOutput("pause_before_edge", gvp_pause, 0);
    tick();
    checkOutput("pause_follows", gvp_pause, 1);
    cmd_pause = 1'b0;
    tick();
    checkOutput("pause_release", gvp_pause, 0);
    cmd_pause = 1'b1;
    pulse(2);
    checkOutput("abort_run_state", state, 0);
    checkOutput("abort_run_gvp_reset", gvp_reset, 1);
    checkOutput("idle_pause_low", gvp_pause, 0);
    cmd_pause = 1'b0;

    // Program load of three records
    pulse(0);
    checkOutput("load_state", state, 1);
    checkOutput("load_tready", s_axis.tready, 1);
    for (int r = 0; r < 3; r++) sendRecord(32'(r), -1);
    checkOutput("write_after_last", state, 2);
    waitState(3'd1, "back_to_collect");
    tick();
    checkRecords("load3");
    checkOutput("vectors_loaded_3", vectors_loaded, 3);

    // Framing errors discard the record; the next good record still lands
    sendRecord(32'h7, 7);
    tick();
    checkOutput("err_early_tlast", err_framing, 1);
    checkOutput("err_stays_collect", state, 1);
    sendRecord(32'h8, 15);
    tick();
    checkOutput("err_missing_tlast_state", state, 1);
    sendRecord(32'h3, -1);
    waitState(3'd1, "good_after_err");
    tick();
    checkRecords("after_err");
    checkOutput("vectors_loaded_4", vectors_loaded, 4);
    checkOutput("err_sticky", err_framing, 1);

    // Stale finished flag is blanked for 16 RUN cycles, DONE on the 17th
    gvp_finished = 1'b1;
    pulse(1);
    checkOutput("collect_start_run", state, 4);
    checkOutput("collect_start_tready", s_axis.tready, 0);
    repeat (16) tick();
    checkOutput("blank_16_still_run", state, 4);
    tick();
    checkOutput("done_on_17", state, 5);
    checkOutput("done_run_done", run_done, 1);
    checkOutput("done_gvp_reset", gvp_reset, 0);
    cmd_pause = 1'b1;
    tick();
    checkOutput("done_pause_low", gvp_pause, 0);
    cmd_pause = 1'b0;
    pulse(1);
    checkOutput("done_start_ignored", state, 5);

    // Reload from DONE, then abort in the tenth WRITE cycle
    gvp_finished = 1'b0;
    pulse(0);
    checkOutput("reload_state", state, 1);
    checkOutput("reload_gvp_reset", gvp_reset, 1);
    checkOutput("reload_clears", {err_framing, vectors_loaded}, 0);
    sendRecord($urandom, -1);
    checkOutput("abort_write_entry", state, 2);
    repeat (9) tick();
    pulse(2);
    checkOutput("abort_write_setvec", gvp_setvec, 0);
    checkOutput("abort_write_state", state, 0);
    checkOutput("abort_write_gvp_reset", gvp_reset, 1);
    tick();
    checkOutput("abort_hold_len", (got_len.size() == 1) ? got_len[0] : -1, 10);
    got_len.delete();
    checkRecords("aborted");
    checkOutput("abort_no_count", vectors_loaded, 0);
    checkOutput("setvec_stable", unstable, 0);

    // Asynchronous reset in the middle of RUN
    repeat (20) tick();
    pulse(1);
    checkOutput("run_again", state, 4);
    repeat (5) tick();
    a_resetn = 1'b0;
    #1;
    checkOutput("async_rst_state", state, 0);
    checkOutput("async_rst_gvp_reset", gvp_reset, 1);
    checkOutput("async_rst_vp_set", gvp_vp_set, 0);
    checkOutput("async_rst_misc", {gvp_pause, gvp_setvec, s_axis.tready, run_done, err_framing}, 0);
    #10;
    a_resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
